// File: rtl/tt_gate_pkg.sv
// Shared types and constants for the truth-table gate evaluator.
// Config FSM states, table-width helper and default table.
package tt_gate_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } cfg_state_t;

  localparam logic [7:0] TT_INIT_DEF = 8'hF4;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_gate_eval_cfg_loader.sv
// Serial truth-table loader: shifts bits MSB-first into a shadow table
// and raises a one-cycle commit strobe once a full table has arrived.
module tt_cfg_loader
  import tt_gate_pkg::*;
#(
  parameter int TT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_ready,
  output logic [TT_W-1:0] shadow,
  output logic            commit
);

  localparam int CW = $clog2(TT_W) + 1;

  cfg_state_t      r_state;
  cfg_state_t      w_state_n;
  logic [TT_W-1:0] r_shadow;
  logic [TT_W-1:0] w_shadow_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic            w_acc;

  // Ready depends on state only, never on cfg_valid.
  assign cfg_ready = (r_state != COMMIT);
  assign w_acc     = cfg_valid && cfg_ready;
  assign shadow    = r_shadow;
  assign commit    = (r_state == COMMIT);

  // State, shadow table and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_shadow <= w_shadow_n;
      r_cnt    <= w_cnt_n;
    end
  end

  // Next-state logic; abort in SHIFT beats a same-cycle bit.
  always_comb begin
    w_state_n  = r_state;
    w_shadow_n = r_shadow;
    w_cnt_n    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_shadow_n = {{(TT_W-1){1'b0}}, cfg_bit};
          w_cnt_n    = CW'(1);
          w_state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_abort) begin
          w_shadow_n = '0;
          w_cnt_n    = '0;
          w_state_n  = IDLE;
        end else if (w_acc) begin
          w_shadow_n = {r_shadow[TT_W-2:0], cfg_bit};
          w_cnt_n    = r_cnt + CW'(1);
          if (r_cnt == CW'(TT_W - 1))
            w_state_n = COMMIT;
        end
      end
      COMMIT: begin
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/tt_gate_eval.sv
// Reprogrammable N_IN-input truth-table gate with a valid/ready
// output register; the table is reloadable over a serial port.
module tt_gate_eval
  import tt_gate_pkg::*;
#(
  parameter  int          N_IN    = 3,
  localparam int          TT_W    = tt_width(N_IN),
  parameter  logic [63:0] TT_INIT = 64'(TT_INIT_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic            cfg_abort,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out,
  input  logic            out_ready,
  output logic [TT_W-1:0] tt_active
);

  logic [TT_W-1:0] r_tt_active;
  logic [TT_W-1:0] w_shadow;
  logic            w_commit;
  logic [N_IN-1:0] w_idx;
  logic            w_accept;
  logic            r_out;
  logic            r_out_valid;

  tt_cfg_loader #(
    .TT_W(TT_W)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_abort(cfg_abort),
    .cfg_ready(cfg_ready),
    .shadow   (w_shadow),
    .commit   (w_commit)
  );

  // Row 0 is the MSB, so the bit index is the complement of the row.
  assign w_idx     = ~in_vec;
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign cfg_done  = w_commit;
  assign tt_active = r_tt_active;
  assign out       = r_out;
  assign out_valid = r_out_valid;

  // Active table: swapped at the end of the commit cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tt_active <= TT_INIT[TT_W-1:0];
    else if (w_commit)
      r_tt_active <= w_shadow;
  end

  // Single result register; result value holds after it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= r_tt_active[w_idx];
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_gate_eval.sv
// Scoreboard bench for tt_gate_eval: directed scenarios plus random
// traffic against a table-and-queue reference model.
module tb_tt_gate_eval;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_ready;
  logic       cfg_abort = 1'b0;
  logic       cfg_done;
  logic       in_valid = 1'b0;
  logic [2:0] in_vec = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out;
  logic       out_ready = 1'b1;
  logic [7:0] tt_active;

  logic       cfg_ready2;
  logic       cfg_done2;
  logic       in_valid2 = 1'b0;
  logic [1:0] in_vec2 = '0;
  logic       in_ready2;
  logic       out_valid2;
  logic       out2;
  logic [3:0] tt_active2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tt_gate_eval #(.N_IN(3)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_abort(cfg_abort),
    .cfg_done(cfg_done),
    .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready),
    .out_valid(out_valid), .out(out),
    .out_ready(out_ready), .tt_active(tt_active)
  );

  tt_gate_eval #(.N_IN(2), .TT_INIT(64'h8)) dut2 (
    .clk(clk), .reset(reset),
    .cfg_valid(1'b0), .cfg_bit(1'b0),
    .cfg_ready(cfg_ready2), .cfg_abort(1'b0),
    .cfg_done(cfg_done2),
    .in_valid(in_valid2), .in_vec(in_vec2),
    .in_ready(in_ready2),
    .out_valid(out_valid2), .out(out2),
    .out_ready(1'b1), .tt_active(tt_active2)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: current table, received config bits, and the
  // queue of results the gate owes downstream.
  logic [7:0] m_tt;
  logic [7:0] m_pend;
  bit         m_commit;
  bit         m_ov;
  bit         m_bits[$];
  bit         q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tt     = 8'hF4;
      m_pend   = 8'h00;
      m_commit = 0;
      m_ov     = 0;
      m_bits.delete();
      q.delete();
    end else begin
      if (in_valid && (!m_ov || out_ready)) begin
        q.push_back(m_tt[7 - int'(in_vec)]);
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (m_commit) begin
        m_tt     = m_pend;
        m_commit = 0;
      end else if (cfg_abort && m_bits.size() > 0) begin
        m_bits.delete();
      end else if (cfg_valid) begin
        m_bits.push_back(cfg_bit);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++)
            m_pend[7 - i] = m_bits[i];
          m_bits.delete();
          m_commit = 1;
        end
      end
    end
  end

  // Monitor: compare whatever the DUT presents mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, !m_ov || out_ready);
      chk("out_valid", out_valid, m_ov);
      chk("cfg_ready", cfg_ready, !m_commit);
      chk("cfg_done", cfg_done, m_commit);
      chk("tt_active", tt_active, m_tt);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          chk("out", out, q[0]);
          if (out_ready)
            void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] t, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = t[7 - i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic sweep(input logic [7:0] tbl);
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      in_vec   = 3'(v);
      tick();
      chk("sweep_out", out, tbl[7 - v]);
      chk("sweep_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic held;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_tt", tt_active, 8'hF4);
    chk("rst_ov", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_done", cfg_done, 0);
    reset = 1'b0;
    tick();

    // Default table sweep; out_valid low before the first accept.
    chk("pre_valid", out_valid, 0);
    sweep(8'hF4);

    // XOR3 load then sweep.
    load(8'h96, 8);
    chk("x_done", cfg_done, 1);
    chk("x_ready", cfg_ready, 0);
    tick();
    chk("x_done_gone", cfg_done, 0);
    chk("x_tt", tt_active, 8'h96);
    sweep(8'h96);

    // Vector accepted during the commit cycle uses the old table.
    load(8'hFF, 8);
    in_valid = 1'b1;
    in_vec   = 3'b100;
    tick();
    chk("commit_old", out, 0);
    tick();
    chk("commit_new", out, 1);
    in_valid = 1'b0;
    tick();

    // Back-pressure: hold for 4 cycles then release.
    load(8'hF4, 8);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 3'b101;
    tick();
    chk("bp_ready", in_ready, 0);
    held = out;
    chk("bp_held0", out, 1);
    for (int i = 0; i < 3; i++) begin
      in_vec = 3'($urandom_range(0, 7));
      tick();
      chk("bp_held", out, held);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      in_vec = 3'(v);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_drain", q.size(), 0);

    // Abort after 5 bits; only the following full load commits.
    load(8'hAA, 5);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    tick();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    tick();
    chk("ab_tt", tt_active, 8'hF4);
    load(8'h01, 8);
    tick();
    chk("ab_tt_new", tt_active, 8'h01);

    // Reset mid-load with a held result.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 3'b111;
    load(8'h3C, 3);
    chk("mr_ov_pre", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mr_tt", tt_active, 8'hF4);
    chk("mr_ov", out_valid, 0);
    chk("mr_cfg_ready", cfg_ready, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    load(8'h3C, 5);
    tick();
    chk("mr_no_commit", tt_active, 8'hF4);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_bit   = 1'($urandom_range(0, 1));
      cfg_abort = ($urandom_range(0, 24) == 0);
      tick();
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rand_drain", q.size(), 0);

    // Two-input instance with table 4'h8: only row 00 is true.
    for (int v = 0; v < 4; v++) begin
      in_valid2 = 1'b1;
      in_vec2   = 2'(v);
      tick();
      chk("n2_out", out2, (v == 0));
      chk("n2_valid", out_valid2, 1);
    end
    in_valid2 = 1'b0;
    chk("n2_tt", tt_active2, 4'h8);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
